branch_unit: RTL
================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter XLEN, default 32: operand, PC and immediate width; legal values 32 or 64.
REQ-002 Parameter BHT_DEPTH, default 16: number of 2-bit predictor counters; power of two, 4..256; BHT_IDX = log2(BHT_DEPTH).
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 is_branch  input  1  request is a conditional branch; 0 means pass-through, never taken.
REQ-008 funct3  input  3  branch condition select.
REQ-009 rs1_data, rs2_data  input  XLEN  compare operands.
REQ-010 pc  input  XLEN  branch instruction address.
REQ-011 imm  input  XLEN  sign-extended branch offset.
REQ-012 pred_taken  input  1  fetch-stage prediction for this request.
REQ-013 lk_pc  input  XLEN  predictor lookup address.
REQ-014 lk_taken  output  1  predictor lookup result, combinational from lk_pc.
REQ-015 out_valid  output  1  result register holds a valid result.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 taken, mispredict, illegal  output  1 each  registered resolution flags.
REQ-018 next_pc  output  XLEN  registered resolved next address.
REQ-019 mispredict_cnt  output  16  saturating count of mispredicted branches.

Function
REQ-020 Handshake: accept when in_valid && in_ready; in_ready = !out_valid || out_ready; result drops when out_valid && out_ready.
REQ-021 Latency: result appears on out_valid exactly one cycle after acceptance; back-to-back acceptance every cycle when out_ready is held high.
REQ-022 Result registers and out_valid hold unchanged while out_valid && !out_ready.
REQ-023 Conditions: funct3 000 BEQ; 001 BNE; 100 BLT (signed); 101 BGE (signed); 110 BLTU; 111 BGEU.
REQ-024 funct3 010 or 011 with is_branch=1: illegal=1, taken=0, mispredict=0, BHT unchanged.
REQ-025 is_branch=0: taken=0, illegal=0, mispredict=0, BHT and mispredict_cnt unchanged.
REQ-026 next_pc = (pc + imm) mod 2^XLEN when taken, else (pc + 4) mod 2^XLEN; wrap-around is silent.
REQ-027 mispredict = taken XOR pred_taken, only for legal branches.
REQ-028 BHT index = pc[BHT_IDX+1:2]; lookup index = lk_pc[BHT_IDX+1:2]; lk_taken = bit 1 of the indexed counter.
REQ-029 BHT update on acceptance of a legal branch: taken increments, saturating at 3; not taken decrements, saturating at 0.
REQ-030 Lookup and update hitting the same index in one cycle: lk_taken reflects the pre-update value.
REQ-031 mispredict_cnt increments by one on acceptance of each mispredicted legal branch; saturates at 0xFFFF.

Reset
REQ-032 rst_n low asynchronously forces: out_valid=0, taken=0, mispredict=0, illegal=0, next_pc=0, mispredict_cnt=0, all BHT counters=2'b01.
REQ-033 in_ready=1 while in reset and on the first cycle after release; a result held mid-stall is discarded by reset.

Verification
REQ-034 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle taken=1, next_pc=0x120, mispredict=1, mispredict_cnt=1.
REQ-035 BLTU with the same operands -> taken=0, next_pc=0x104, mispredict=0.
REQ-036 Three taken branches at pc=0x40, BHT_DEPTH=16 -> counter 1->2->3->3; lk_pc=0x40 gives lk_taken=0 before the first update and 1 thereafter.
REQ-037 out_ready=0 with results pending -> in_ready=0, outputs frozen; out_ready=1 -> drains one result per cycle, no loss or duplication.
REQ-038 funct3=010, is_branch=1 -> illegal=1, taken=0, next_pc=pc+4; pc=0xFFFFFFFC not taken -> next_pc=0x0.
REQ-039 rst_n pulsed low during a stall -> out_valid=0 immediately, BHT reads 2'b01 everywhere, mispredict_cnt=0.

Source files
------------

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - conditional branch resolver with 2-bit BHT and mispredict counter
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   is_branch, funct3     request kind and branch condition select
//   rs1_data, rs2_data    compare operands
//   pc, imm, pred_taken   branch address, sign-extended offset, fetch prediction
//   lk_pc / lk_taken      combinational predictor lookup
//   out_valid / out_ready result handshake
//   taken, mispredict,    registered resolution flags
//   illegal, next_pc
//   mispredict_cnt        saturating mispredicted-branch count
module branch_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_branch,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            mispredict,
  output logic            illegal,
  output logic [XLEN-1:0] next_pc,
  output logic [15:0]     mispredict_cnt
);

  localparam int BHT_IDX = $clog2(BHT_DEPTH);

  logic            out_valid_q, out_valid_d;
  logic            taken_q, mispredict_q, illegal_q;
  logic [XLEN-1:0] next_pc_q;
  logic [15:0]     cnt_q, cnt_d;
  logic [1:0]      bht_q [BHT_DEPTH];

  logic               accept;
  logic               legal;
  logic               cond;
  logic               taken_c, illegal_c, mispredict_c;
  logic [XLEN-1:0]    next_pc_c;
  logic [BHT_IDX-1:0] upd_idx, lk_idx;
  logic               bht_we;
  logic [1:0]         bht_cur, bht_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // funct3 010/011 are the only reserved encodings
  assign legal = (funct3 != 3'b010) && (funct3 != 3'b011);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_data == rs2_data);
      3'b001:  cond = (rs1_data != rs2_data);
      3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond = (rs1_data <  rs2_data);
      3'b111:  cond = (rs1_data >= rs2_data);
      default: cond = 1'b0;
    endcase
  end

  assign taken_c      = is_branch && legal && cond;
  assign illegal_c    = is_branch && !legal;
  assign mispredict_c = is_branch && legal && (taken_c ^ pred_taken);
  assign next_pc_c    = taken_c ? (pc + imm) : (pc + XLEN'(4));

  // Predictor indexing skips the two always-zero instruction alignment bits
  assign upd_idx  = pc[BHT_IDX+1:2];
  assign lk_idx   = lk_pc[BHT_IDX+1:2];
  // Reads the registered table, so a same-cycle update is not visible yet
  assign lk_taken = bht_q[lk_idx][1];

  assign bht_we  = accept && is_branch && legal;
  assign bht_cur = bht_q[upd_idx];

  always_comb begin
    bht_d = bht_cur;
    if (taken_c) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'b01;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && mispredict_c && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      next_pc_q    <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else begin
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        taken_q      <= taken_c;
        mispredict_q <= mispredict_c;
        illegal_q    <= illegal_c;
        next_pc_q    <= next_pc_c;
      end
      if (bht_we) bht_q[upd_idx] <= bht_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign taken          = taken_q;
  assign mispredict     = mispredict_q;
  assign illegal        = illegal_q;
  assign next_pc        = next_pc_q;
  assign mispredict_cnt = cnt_q;

endmodule
